// File: rtl/dcache_dm_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dcache_dm_wb                                                     |
// | Brief   : Direct-mapped write-back/write-allocate data cache with a        |
// |           128-bit block memory port. DCACHE_PERF_EN adds hit/miss counters.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dcache_dm_wb #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_ren,
  input  logic         proc_wen,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int c_num_lines = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  logic [c_num_lines-1:0] r_valid;
  logic [c_num_lines-1:0] r_dirty;
  logic [TAG_W-1:0]       r_tag  [c_num_lines];
  logic [127:0]           r_data [c_num_lines];

  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [27:0]            r_mem_addr;
  logic [127:0]           r_mem_wdata;
  logic [INDEX_W-1:0]     r_miss_idx;
  logic [TAG_W-1:0]       r_miss_tag;

  logic                   w_req;
  logic [1:0]             w_off;
  logic [INDEX_W-1:0]     w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_idle_hit;
  logic                   w_miss_start;
  logic [31:0]            w_rd_word;

  assign w_req        = proc_ren | proc_wen;
  assign w_off        = proc_addr[1:0];
  assign w_idx        = proc_addr[INDEX_W+1:2];
  assign w_tag        = proc_addr[29:INDEX_W+2];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle_hit   = (r_state == S_IDLE) && w_req && w_hit;
  assign w_miss_start = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_rd_word    = r_data[w_idx][{w_off, 5'b0} +: 32];

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_comb begin
    w_next_state = r_state;
    proc_stall   = 1'b0;
    proc_rdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            if (!proc_wen) proc_rdata = w_rd_word;
          end else begin
            proc_stall   = 1'b1;
            w_next_state = r_dirty[w_idx] ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        proc_stall = 1'b1;
        if (mem_ready) w_next_state = S_ALLOC;
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        if (mem_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Miss index/tag are latched so a withdrawn request still installs its refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_miss_idx  <= '0;
      r_miss_tag  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit && proc_wen) r_dirty[w_idx] <= 1'b1;
          if (w_miss_start) begin
            r_miss_idx <= w_idx;
            r_miss_tag <= w_tag;
            if (r_dirty[w_idx]) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx};
              r_mem_wdata <= r_data[w_idx];
            end else begin
              r_mem_read <= 1'b1;
              r_mem_addr <= proc_addr[29:2];
            end
          end
        end
        S_WB: begin
          if (mem_ready) begin
            r_mem_write         <= 1'b0;
            r_dirty[r_miss_idx] <= 1'b0;
            r_mem_read          <= 1'b1;
            r_mem_addr          <= {r_miss_tag, r_miss_idx};
          end
        end
        S_ALLOC: begin
          if (mem_ready) begin
            r_mem_read          <= 1'b0;
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle_hit && proc_wen) r_data[w_idx][{w_off, 5'b0} +: 32] <= proc_wdata;
    if (r_state == S_ALLOC && mem_ready) begin
      r_data[r_miss_idx] <= mem_rdata;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        r_missed;

  // r_missed suppresses counting the post-refill hit of a request that already missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_missed   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_idle_hit) begin
        if (!r_missed) r_hit_cnt <= r_hit_cnt + 32'd1;
        r_missed <= 1'b0;
      end else if (w_miss_start) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
        r_missed   <= 1'b1;
      end else begin
        r_missed <= 1'b0;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_dm_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dcache_dm_wb                                                  |
// | Brief   : Directed self-checking bench for dcache_dm_wb.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dcache_dm_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_ren;
  logic         proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  hit_snap;
  logic [31:0]  miss_snap;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] c_blk_a = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] c_blk_b = 128'h88888888_77777777_66666666_55555555;
  logic [31:0] exp_b [4];

  always #5 clk = ~clk;

  dcache_dm_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_b[0] = 32'h55555555;
    exp_b[1] = 32'h66666666;
    exp_b[2] = 32'h77777777;
    exp_b[3] = 32'h88888888;
    rst_n = 1'b0; proc_ren = 1'b0; proc_wen = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall", proc_stall, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", proc_rdata, 0);
    cyc(); rst_n = 1'b1;

    // Cold read of 0x05
    cyc(); proc_ren = 1'b1; proc_addr = 30'h05;
    @(negedge clk); chk("cold_idle_stall", proc_stall, 1);
    cyc();
    @(negedge clk);
    chk("cold_alloc_read", mem_read, 1);
    chk("cold_alloc_write", mem_write, 0);
    chk("cold_alloc_addr", mem_addr, 28'h1);
    chk("cold_alloc_stall", proc_stall, 1);
    cyc(); cyc();
    cyc(); mem_ready = 1'b1; mem_rdata = c_blk_a;
    @(negedge clk); chk("cold_hold_read", mem_read, 1);
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("cold_post_stall", proc_stall, 0);
    chk("cold_post_rdata", proc_rdata, 32'h22222222);
    chk("cold_post_read", mem_read, 0);

    // Write hit, then dirty eviction by 0x25
`ifdef DCACHE_PERF_EN
    hit_snap = hit_cnt; miss_snap = miss_cnt;
`endif
    cyc(); proc_ren = 1'b0; proc_wen = 1'b1; proc_wdata = 32'hDEADBEEF; proc_addr = 30'h05;
    @(negedge clk);
    chk("wr_hit_stall", proc_stall, 0);
    chk("wr_hit_mem_write", mem_write, 0);
    cyc(); proc_wen = 1'b0; proc_ren = 1'b1; proc_addr = 30'h25;
    @(negedge clk); chk("evict_idle_stall", proc_stall, 1);
    cyc();
    @(negedge clk);
    chk("wb_write", mem_write, 1);
    chk("wb_read", mem_read, 0);
    chk("wb_addr", mem_addr, 28'h001);
    chk("wb_wdata", mem_wdata, 128'h44444444_33333333_DEADBEEF_11111111);
    cyc(); mem_ready = 1'b1;
    @(negedge clk); chk("wb_hold_write", mem_write, 1);
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("wb_alloc_read", mem_read, 1);
    chk("wb_alloc_write", mem_write, 0);
    chk("wb_alloc_addr", mem_addr, 28'h009);
    cyc(); mem_ready = 1'b1; mem_rdata = c_blk_b;
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("evict_post_stall", proc_stall, 0);
    chk("evict_post_rdata", proc_rdata, 32'h66666666);
`ifdef DCACHE_PERF_EN
    chk("perf_hit_delta", hit_cnt - hit_snap, 1);
    chk("perf_miss_delta", miss_cnt - miss_snap, 1);
`endif

    // Clean eviction: 0x05 then 0x25, no writes
    cyc(); proc_addr = 30'h05;
    @(negedge clk); chk("clean1_stall", proc_stall, 1);
    cyc();
    @(negedge clk);
    chk("clean1_write", mem_write, 0);
    chk("clean1_read", mem_read, 1);
    chk("clean1_addr", mem_addr, 28'h001);
    cyc(); mem_ready = 1'b1; mem_rdata = c_blk_a;
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("clean1_rdata", proc_rdata, 32'h22222222);
    chk("clean1_post_stall", proc_stall, 0);
    cyc(); proc_addr = 30'h25;
    @(negedge clk); chk("clean2_stall", proc_stall, 1);
    cyc();
    @(negedge clk);
    chk("clean2_write", mem_write, 0);
    chk("clean2_read", mem_read, 1);
    chk("clean2_addr", mem_addr, 28'h009);
    cyc(); mem_ready = 1'b1; mem_rdata = c_blk_b;
    @(negedge clk); chk("clean2_hold_write", mem_write, 0);
    cyc(); mem_ready = 1'b0;
    @(negedge clk); chk("clean2_rdata", proc_rdata, 32'h66666666);

    // Stray mem_ready while idle must be ignored
    cyc(); proc_ren = 1'b0; mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("stray_read", mem_read, 0);
    chk("stray_write", mem_write, 0);

    // Back-to-back hits on words 0..3 of block at 0x24
    for (int i = 0; i < 4; i++) begin
      cyc(); proc_ren = 1'b1; proc_addr = 30'h24 + 30'(i);
      @(negedge clk);
      chk("b2b_stall", proc_stall, 0);
      chk("b2b_rdata", proc_rdata, exp_b[i]);
      chk("b2b_mem_read", mem_read, 0);
      chk("b2b_mem_write", mem_write, 0);
    end

    // Reset mid-refill
    cyc(); proc_addr = 30'h05;
    cyc();
    @(negedge clk); chk("rstmid_read_before", mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_read_async", mem_read, 0);
    chk("rstmid_write_async", mem_write, 0);
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("rstmid_remiss_stall", proc_stall, 1);
    cyc();
    @(negedge clk);
    chk("rstmid_realloc_read", mem_read, 1);
    chk("rstmid_realloc_addr", mem_addr, 28'h001);
    cyc(); mem_ready = 1'b1; mem_rdata = c_blk_a;
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_post_stall", proc_stall, 0);
    chk("rstmid_post_rdata", proc_rdata, 32'h22222222);
    cyc(); proc_addr = 30'h24;
    @(negedge clk); chk("rstmid_old_line_invalid", proc_stall, 1);
    cyc();
    @(negedge clk); chk("rstmid_old_alloc_write", mem_write, 0);
    cyc(); mem_ready = 1'b1; mem_rdata = c_blk_b;
    cyc(); mem_ready = 1'b0; proc_ren = 1'b0;
    @(negedge clk); chk("end_idle_stall", proc_stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_dm_wb.md
Name: dcache_dm_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the pipeline's D cache port (responder side of ren/wen/addr/wdata/stall/rdata) and a 128-bit block-wide main memory.
- Hits return data combinationally with no stall. Misses hold the stall until a dirty-victim writeback and a block refill have completed.
- One instance serves DCACHE. The instruction-side port ties proc_wen low and uses the same block.

Parameters:
- INDEX_W, 3, index bits; the cache holds 2^INDEX_W blocks of 4 words each (128 bits per block).
- TAG_W, 25, tag bits; must equal 30-2-INDEX_W.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- proc_ren  input  1  read request, held until proc_stall is low
- proc_wen  input  1  write request, held until proc_stall is low
- proc_addr  input  30  word address; [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag
- proc_wdata  input  32  write data
- proc_stall  output  1  high while the request cannot complete this cycle
- proc_rdata  output  32  read data, valid when proc_ren=1 and proc_stall=0
- mem_read  output  1  block read request to memory
- mem_write  output  1  block write request to memory
- mem_addr  output  28  block address (word address >> 2)
- mem_wdata  output  128  victim block; word 0 in bits [31:0]
- mem_rdata  input  128  refill block; word 0 in bits [31:0]
- mem_ready  input  1  one-cycle pulse: current mem_read/mem_write is complete

Behaviour:
- Reset (async, rst_n=0):
  - All valid and dirty bits are cleared and state goes to IDLE.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
  - proc_stall is combinational, so it is 0 whenever no request is present.
  - Tag and data arrays need not be reset.
- Request: req = proc_ren | proc_wen. If both are high, the request is treated as a write.
- Hit = valid[idx] & (tag[idx]==addr tag). The hit is evaluated combinationally in IDLE only.
- States:
  - IDLE:
    - req & hit: proc_stall=0. A read drives proc_rdata = selected word in the same cycle. A write updates that word at the clock edge and sets dirty[idx]=1.
    - req & miss & dirty: proc_stall=1, next state WB.
    - req & miss & clean: proc_stall=1, next state ALLOC.
    - No req: proc_stall=0 and the state is unchanged.
  - WB:
    - Outputs: mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx]. These are registered and stay stable until mem_ready.
    - On mem_ready: clear dirty[idx], next state ALLOC.
    - proc_stall=1 throughout.
  - ALLOC:
    - Outputs: mem_read=1, mem_addr=proc_addr[29:2], stable until mem_ready.
    - On mem_ready: data[idx]=mem_rdata, tag[idx]=addr tag, valid=1, dirty=0, next state IDLE.
    - proc_stall=1 throughout.
- Post-refill: in the cycle after the refill the request hits in IDLE and completes with proc_stall=0. Miss latency = 1 (IDLE) + memory wait(s) + 1.
- mem_read and mem_write are never high together. Both drop in the cycle after mem_ready is sampled.
- mem_ready while idle, or while in the opposite access state, is ignored.
- The processor holds addr, wdata, ren and wen constant while proc_stall=1. If the request is withdrawn mid-miss, the in-flight memory transaction still completes and the refill is still installed.
- Reset asserted mid-WB or mid-ALLOC aborts immediately: mem_read and mem_write drop, and all lines become invalid. A victim writeback lost this way is acceptable.
- Index wrap: conflicting addresses (same index, different tag) evict each other. There is no associativity.

Optional Feature:
- Macro: DCACHE_PERF_EN.
- When defined, adds two output ports, hit_cnt[31:0] and miss_cnt[31:0]. Both are reset to 0.
- hit_cnt increments once per request completing in IDLE with no preceding miss for that request.
- miss_cnt increments once on each IDLE→WB or IDLE→ALLOC transition.
- Both counters wrap at 2^32.
- When the macro is undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold read:
  - Stimulus: after reset, ren addr=0x0000_0005 (index 1, word 1); memory returns 128'h4444_3333_2222_1111 after 3 cycles.
  - Response: ALLOC with mem_addr=0x000_0001, then the next IDLE cycle gives stall=0 and rdata=0x2222_2222.
- Write hit then dirty eviction:
  - Stimulus: write 0xDEAD_BEEF to 0x05 (hit). Then read 0x25 (same index 1, different tag).
  - Response: WB with mem_addr=0x001, mem_wdata word1=0xDEAD_BEEF, then ALLOC with mem_addr=0x009.
- Clean eviction:
  - Stimulus: read 0x05, then read 0x25 with no intervening write.
  - Response: no mem_write ever asserted; straight to ALLOC.
- Back-to-back hits:
  - Stimulus: 4 consecutive reads of words 0–3 of a filled block.
  - Response: proc_stall=0 every cycle; mem_read and mem_write stay low.
- Reset mid-refill:
  - Stimulus: assert rst_n=0 while mem_read=1.
  - Response: mem_read=0 asynchronously; a subsequent read of the same address misses again.
- DCACHE_PERF_EN:
  - Stimulus: the write-hit-then-dirty-eviction sequence above.
  - Response: hit_cnt=1, miss_cnt=1.
